// File: rtl/exception_ctrl_pkg.sv
// Shared definitions for the memory-stage exception logic: exception codes,
// CP0 register addresses, the default exception vector and FSM states.
package exception_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } exc_state_e;

  // CP0 write-forwarding helper: WB-stage MTC0 wins over the register value.
  function automatic logic [31:0] cp0_fwd(input logic [31:0] reg_val,
                                          input logic        we,
                                          input logic [4:0]  waddr,
                                          input logic [4:0]  target,
                                          input logic [31:0] wdata);
    return (we && (waddr == target)) ? wdata : reg_val;
  endfunction

endpackage

// File: rtl/exception_ctrl_int_sync.sv
// Per-bit flop-chain synchroniser for asynchronous interrupt pins.
module exception_ctrl_int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= async_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/exception_ctrl.sv
// Memory-stage exception arbiter: picks one exception by MIPS priority for CP0
// in the same cycle, then issues a one-cycle registered flush and redirect PC.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        inst_valid_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] mem_addr_i,
  input  logic        adel_if_i,
  input  logic        ri_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        ov_i,
  input  logic        trap_i,
  input  logic        adel_i,
  input  logic        ades_i,
  input  logic        eret_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic [5:0]  int_sync_o,
  output logic        flush_o,
  output logic [31:0] newpc_o
);

  exc_state_e  state_q;
  logic        flush_q;
  logic [31:0] newpc_q;

  logic [31:0] status_f, cause_f, epc_f;
  logic [7:0]  int_pending;
  logic        int_take;
  logic [31:0] sel_code, sel_bad;
  logic        accept_ok;
  logic [31:0] exc_code, exc_bad;
  logic        unused_bits;

  exception_ctrl_int_sync #(
    .WIDTH  (6),
    .STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (int_i),
    .sync_o  (int_sync_o)
  );

  always_comb begin
    status_f = cp0_fwd(cp0_status_i, wb_cp0_we_i, wb_cp0_waddr_i, CP0_REG_STATUS, wb_cp0_wdata_i);
    epc_f    = cp0_fwd(cp0_epc_i, wb_cp0_we_i, wb_cp0_waddr_i, CP0_REG_EPC, wb_cp0_wdata_i);
    // Only the software-interrupt bits of Cause are writable by MTC0.
    cause_f  = cp0_cause_i;
    if (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_REG_CAUSE)) begin
      cause_f[9:8] = wb_cp0_wdata_i[9:8];
    end
    int_pending = {int_sync_o, cause_f[9:8]} & status_f[15:8];
    int_take    = (|int_pending) && status_f[0] && !status_f[1] && inst_valid_i;
  end

  always_comb begin
    sel_bad = 32'h0;
    if (int_take)       sel_code = EXC_INT;
    else if (adel_if_i) begin
      sel_code = EXC_ADEL;
      sel_bad  = pc_i;
    end
    else if (ri_i)      sel_code = EXC_RI;
    else if (syscall_i) sel_code = EXC_SYS;
    else if (break_i)   sel_code = EXC_BP;
    else if (ov_i)      sel_code = EXC_OV;
    else if (trap_i)    sel_code = EXC_TR;
    else if (adel_i) begin
      sel_code = EXC_ADEL;
      sel_bad  = mem_addr_i;
    end
    else if (ades_i) begin
      sel_code = EXC_ADES;
      sel_bad  = mem_addr_i;
    end
    else if (eret_i)    sel_code = EXC_ERET;
    else                sel_code = EXC_NONE;
  end

  assign accept_ok = (state_q == ST_IDLE) && !stall_i && inst_valid_i;
  assign exc_code  = accept_ok ? sel_code : EXC_NONE;
  assign exc_bad   = accept_ok ? sel_bad  : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      flush_q <= 1'b0;
      newpc_q <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          flush_q <= 1'b0;
          if (exc_code != EXC_NONE) begin
            state_q <= ST_FLUSH;
            flush_q <= 1'b1;
            newpc_q <= (exc_code == EXC_ERET) ? epc_f : EXC_VECTOR;
          end
        end
        ST_FLUSH: begin
          flush_q <= 1'b0;
          state_q <= ST_HOLD;
        end
        // CP0's EXL/EPC update becomes visible here, so nothing is accepted.
        ST_HOLD: begin
          flush_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          flush_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign excepttype_o        = exc_code;
  assign bad_addr_o          = exc_bad;
  assign current_inst_addr_o = pc_i;
  assign is_in_delayslot_o   = is_in_delayslot_i;
  assign flush_o             = flush_q;
  assign newpc_o             = newpc_q;

  assign unused_bits = ^{status_f[31:16], status_f[7:2], cause_f[31:10], cause_f[7:0]};

endmodule
